// File: rtl/cache_addr_splitter_if.sv
// Request/response bundle for cache_addr_splitter: an incoming byte-range
// request channel and an outgoing line-aligned piece channel.
interface cache_addr_splitter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 16
);
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [OFFSET_BITS-1:0] req_len;

  logic                   out_valid;
  logic                   out_ready;
  logic [TAG_BITS-1:0]    out_tag;
  logic [INDEX_BITS-1:0]  out_index;
  logic [OFFSET_BITS-1:0] out_offset;
  logic [OFFSET_BITS-1:0] out_len;
  logic                   out_first;
  logic                   out_last;

  // Requester / piece consumer side
  modport master (
    output req_valid, req_addr, req_len, out_ready,
    input  req_ready, out_valid, out_tag, out_index, out_offset, out_len,
           out_first, out_last
  );

  // Splitter side
  modport slave (
    input  req_valid, req_addr, req_len, out_ready,
    output req_ready, out_valid, out_tag, out_index, out_offset, out_len,
           out_first, out_last
  );
endinterface

// File: rtl/cache_addr_splitter.sv
// Splits a byte-range access into at most two cache-line-aligned pieces,
// decomposing each piece address into tag / index / offset. Counts
// line-crossing requests in a saturating 16-bit counter.
module cache_addr_splitter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_addr_splitter_if.slave  bus,
  output logic [15:0]           split_cnt
);
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int LINE_BITS   = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                 state_q;
  logic                   out_valid_q;
  logic                   first_q;
  logic                   last_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic [INDEX_BITS-1:0]  index_q;
  logic [OFFSET_BITS-1:0] offset_q;
  logic [OFFSET_BITS-1:0] len_q;
  logic [TAG_BITS-1:0]    p2_tag_q;
  logic [INDEX_BITS-1:0]  p2_index_q;
  logic [OFFSET_BITS-1:0] p2_len_q;
  logic [15:0]            split_cnt_q;

  logic [OFFSET_BITS-1:0] req_off;
  logic [OFFSET_BITS:0]   end_sum;
  logic                   crossing;
  logic [LINE_BITS-1:0]   line_cur;
  logic [LINE_BITS-1:0]   line_nxt_d;
  logic                   req_rdy;
  logic                   accept;
  logic                   out_fire;

  // Request decode: crossing test, next-line address and handshakes
  always_comb begin
    req_off    = bus.req_addr[OFFSET_BITS-1:0];
    end_sum    = {1'b0, req_off} + {1'b0, bus.req_len};
    crossing   = end_sum[OFFSET_BITS];
    line_cur   = bus.req_addr[ADDR_WIDTH-1:OFFSET_BITS];
    line_nxt_d = line_cur + LINE_BITS'(1);
    out_fire   = out_valid_q & bus.out_ready;
    req_rdy    = rst_n & (state_q == IDLE) & (~out_valid_q | bus.out_ready);
    accept     = bus.req_valid & req_rdy;
  end

  // FSM with registered output piece, pending second piece and split counter.
  // Piece-1 length is BLOCK_BYTES-1-offset, i.e. ~offset; piece-2 length is
  // (offset+len) - BLOCK_BYTES, i.e. the low bits of the carry-out sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      index_q     <= '0;
      offset_q    <= '0;
      len_q       <= '0;
      p2_tag_q    <= '0;
      p2_index_q  <= '0;
      p2_len_q    <= '0;
      split_cnt_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      tag_q       <= line_cur[LINE_BITS-1:INDEX_BITS];
      index_q     <= line_cur[INDEX_BITS-1:0];
      offset_q    <= req_off;
      len_q       <= crossing ? ~req_off : bus.req_len;
      first_q     <= 1'b1;
      last_q      <= ~crossing;
      if (crossing) begin
        state_q    <= SPLIT;
        p2_tag_q   <= line_nxt_d[LINE_BITS-1:INDEX_BITS];
        p2_index_q <= line_nxt_d[INDEX_BITS-1:0];
        p2_len_q   <= end_sum[OFFSET_BITS-1:0];
        if (split_cnt_q != '1) split_cnt_q <= split_cnt_q + 16'd1;
      end
    end else if (state_q == SPLIT && out_fire) begin
      state_q  <= IDLE;
      tag_q    <= p2_tag_q;
      index_q  <= p2_index_q;
      offset_q <= '0;
      len_q    <= p2_len_q;
      first_q  <= 1'b0;
      last_q   <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_index  = index_q;
  assign bus.out_offset = offset_q;
  assign bus.out_len    = len_q;
  assign bus.out_first  = first_q;
  assign bus.out_last   = last_q;
  assign split_cnt      = split_cnt_q;
endmodule

// File: tb/tb_cache_addr_splitter.sv
// Scoreboard bench for cache_addr_splitter at default parameters.
module tb_cache_addr_splitter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] split_cnt;

  always #5 clk = ~clk;

  cache_addr_splitter_if #(.ADDR_WIDTH(32), .BLOCK_BYTES(64), .NUM_SETS(16)) bus ();

  cache_addr_splitter #(.ADDR_WIDTH(32), .BLOCK_BYTES(64), .NUM_SETS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .split_cnt (split_cnt)
  );

  typedef struct packed {
    logic [21:0] tag;
    logic [3:0]  idx;
    logic [5:0]  off;
    logic [5:0]  len;
    logic        first;
    logic        last;
  } piece_t;

  piece_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_piece(input logic [21:0] t, input logic [3:0] i, input logic [5:0] o,
                              input logic [5:0] l, input logic f, input logic la);
    piece_t p;
    p.tag = t; p.idx = i; p.off = o; p.len = l; p.first = f; p.last = la;
    exp_q.push_back(p);
  endtask

  function automatic piece_t cur_piece();
    piece_t p;
    p.tag = bus.out_tag; p.idx = bus.out_index; p.off = bus.out_offset;
    p.len = bus.out_len; p.first = bus.out_first; p.last = bus.out_last;
    return p;
  endfunction

  // Present a request and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [5:0] l);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: addr 0x%08h never accepted", a);
    bus.req_valid = 1'b0;
  endtask

  task automatic monitor();
    piece_t act;
    piece_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        act = cur_piece();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL piece_unexpected: got tag=%h idx=%h off=%h len=%h first=%b last=%b, required none",
                   act.tag, act.idx, act.off, act.len, act.first, act.last);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_bad++;
            $display("FAIL piece: got tag=%h idx=%h off=%h len=%h first=%b last=%b required tag=%h idx=%h off=%h len=%h first=%b last=%b",
                     act.tag, act.idx, act.off, act.len, act.first, act.last,
                     exp.tag, exp.idx, exp.off, exp.len, exp.first, exp.last);
          end
        end
      end
    end
  endtask

  task automatic run_all();
    piece_t snap;
    time    t0;

    // Reset state
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_first_last", 64'({bus.out_first, bus.out_last}), 0);
    chk("rst_fields", 64'(cur_piece()), 0);
    chk("rst_split_cnt", 64'(split_cnt), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.req_ready), 1);
    @(posedge clk); #1;

    // Single piece, 1-cycle latency
    expect_piece(22'h4, 4'h8, 6'h34, 6'd3, 1'b1, 1'b1);
    send(32'h0000_1234, 6'd3);
    bus.req_valid = 1'b0;
    chk("single_latency_valid", 64'(bus.out_valid), 1);
    chk("single_split_cnt", 64'(split_cnt), 0);
    @(posedge clk); #1;
    chk("single_drained", 64'(bus.out_valid), 0);

    // Crossing request, one bubble on req_ready
    expect_piece(22'h4, 4'h0, 6'h3C, 6'd3, 1'b1, 1'b0);
    expect_piece(22'h4, 4'h1, 6'h00, 6'd3, 1'b0, 1'b1);
    send(32'h0000_103C, 6'd7);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("split_bubble", 64'(bus.req_ready), 0);
    @(negedge clk);
    chk("split_ready_back", 64'(bus.req_ready), 1);
    chk("split_cnt_1", 64'(split_cnt), 1);
    @(posedge clk); #1;

    // Top-of-address-space wrap
    expect_piece(22'h3FFFFF, 4'hF, 6'h38, 6'd7, 1'b1, 1'b0);
    expect_piece(22'h0, 4'h0, 6'h00, 6'd7, 1'b0, 1'b1);
    send(32'hFFFF_FFF8, 6'd15);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_split_cnt", 64'(split_cnt), 2);
    chk("wrap_drained", 64'(bus.out_valid), 0);

    // Back-to-back non-crossing requests with a 3-cycle downstream stall
    bus.out_ready = 1'b0;
    expect_piece(22'h8, 4'h1, 6'h00, 6'h3F, 1'b1, 1'b1);
    send(32'h0000_2040, 6'h3F);
    expect_piece(22'h1, 4'h0, 6'h05, 6'h3A, 1'b1, 1'b1);
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0405; bus.req_len = 6'h3A;
    snap = cur_piece();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_stable", 64'(cur_piece()), 64'(snap));
      chk("stall_valid", 64'(bus.out_valid), 1);
      chk("stall_req_ready", 64'(bus.req_ready), 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(32'h0000_0405, 6'h3A);
    chk("b2b_valid_held", 64'(bus.out_valid), 1);
    expect_piece(22'h2AF37B, 4'hD, 6'h3F, 6'h00, 1'b1, 1'b1);
    expect_piece(22'h4, 4'h8, 6'h34, 6'h0B, 1'b1, 1'b1);
    t0 = $time;
    send(32'hABCD_EF7F, 6'h00);
    send(32'h0000_1234, 6'h0B);
    bus.req_valid = 1'b0;
    chk("b2b_rate", 64'($time - t0), 20);
    chk("b2b_valid_last", 64'(bus.out_valid), 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset while piece 1 of a split is stalled
    bus.out_ready = 1'b0;
    send(32'h0000_103C, 6'd7);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.out_valid), 1);
    chk("pre_rst_last", 64'(bus.out_last), 0);
    chk("pre_rst_split_cnt", 64'(split_cnt), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 0);
    chk("mid_rst_fields", 64'(cur_piece()), 0);
    chk("mid_rst_split_cnt", 64'(split_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_piece2_after_rst", 64'(bus.out_valid), 0);
    end
    @(posedge clk); #1;

    // Saturation of split_cnt
    for (int k = 0; k < 65536; k++) begin
      if (k == 65534) chk("split_cnt_pre_sat", 64'(split_cnt), 16'hFFFE);
      expect_piece(22'h4, 4'h0, 6'h3C, 6'd3, 1'b1, 1'b0);
      expect_piece(22'h4, 4'h1, 6'h00, 6'd3, 1'b0, 1'b1);
      send(32'h0000_103C, 6'd7);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("split_cnt_sat", 64'(split_cnt), 16'hFFFF);
    expect_piece(22'h4, 4'h0, 6'h3C, 6'd3, 1'b1, 1'b0);
    expect_piece(22'h4, 4'h1, 6'h00, 6'd3, 1'b0, 1'b1);
    send(32'h0000_103C, 6'd7);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("split_cnt_hold", 64'(split_cnt), 16'hFFFF);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      run_all();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
